// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor tile:
// FSM state encoding, wrapper pin indices and the output-enable mask.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Control/status pin indices on the uio bus
  localparam int PIN_LOAD_A = 0;
  localparam int PIN_LOAD_B = 1;
  localparam int PIN_START  = 2;
  localparam int PIN_BUSY   = 3;
  localparam int PIN_DONE   = 4;
  localparam int PIN_BORROW = 5;

  localparam logic [7:0] UIO_OE_MASK = 8'h38;

  localparam int WIDTH = 8;
  localparam logic [2:0] LAST_BIT = 3'd7;

endpackage

// File: rtl/tt_um_serial_sub_bit.sv
// Combinational full-subtractor cell: d = a - b - bin, with borrow out.
// Ports: a, b, bin (in, 1b); d, bout (out, 1b).
module serial_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic x;

  assign x    = a ^ b;
  assign d    = x ^ bin;
  assign bout = (~a & b) | (~x & bin);

endmodule

// File: rtl/tt_um_serial_sub.sv
// Bit-serial 8-bit subtractor tile (LSB-first ripple borrow, one bit/clk).
// Ports: clk, rst_n (sync, active-low), ena, ui_in (operand byte),
// uio_in (load_a/load_b/start), uo_out (A-B), uio_out (busy/done/borrow),
// uio_oe (constant output-enable mask).
module tt_um_serial_sub
  import serial_sub_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t     state;
  state_t     state_n;

  logic [7:0] a_q;
  logic [7:0] a_n;
  logic [7:0] b_q;
  logic [7:0] b_n;
  logic [7:0] diff_sh;
  logic [7:0] diff_n;
  logic [7:0] res_q;
  logic [7:0] res_n;
  logic [2:0] cnt;
  logic [2:0] cnt_n;
  logic       bor_q;
  logic       bor_n;
  logic       bout_q;
  logic       bout_n;

  logic       load_a;
  logic       load_b;
  logic       start;
  logic       any_load;

  logic       d;
  logic       bout;
  logic [7:0] shifted;

  logic       unused;

  assign load_a   = uio_in[PIN_LOAD_A];
  assign load_b   = uio_in[PIN_LOAD_B];
  assign start    = uio_in[PIN_START];
  assign any_load = load_a | load_b;

  assign unused = &{1'b0, uio_in[7:3]};

  serial_sub_bit u_bit (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bor_q),
    .d    (d),
    .bout (bout)
  );

  // New difference bit enters at the MSB, so after 8 shifts
  // bit 0 of the operands has landed in bit 0 of the result.
  assign shifted = {d, diff_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      diff_sh <= '0;
      bor_q   <= 1'b0;
      cnt     <= '0;
      res_q   <= '0;
      bout_q  <= 1'b0;
    end else if (ena) begin
      a_q     <= a_n;
      b_q     <= b_n;
      diff_sh <= diff_n;
      bor_q   <= bor_n;
      cnt     <= cnt_n;
      res_q   <= res_n;
      bout_q  <= bout_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    diff_n  = diff_sh;
    bor_n   = bor_q;
    cnt_n   = cnt;
    res_n   = res_q;
    bout_n  = bout_q;

    unique case (state)
      IDLE, DONE: begin
        if (load_a) a_n = ui_in;
        if (load_b) b_n = ui_in;
        // A load always wins over a start in the same cycle.
        if (any_load) begin
          state_n = IDLE;
        end else if (start) begin
          state_n = RUN;
          cnt_n   = '0;
          bor_n   = 1'b0;
          diff_n  = '0;
        end
      end
      RUN: begin
        diff_n = shifted;
        a_n    = {1'b0, a_q[WIDTH-1:1]};
        b_n    = {1'b0, b_q[WIDTH-1:1]};
        bor_n  = bout;
        cnt_n  = cnt + 3'd1;
        if (cnt == LAST_BIT) begin
          res_n   = shifted;
          bout_n  = bout;
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    uio_out             = '0;
    uio_out[PIN_BUSY]   = (state == RUN);
    uio_out[PIN_DONE]   = (state == DONE);
    uio_out[PIN_BORROW] = bout_q;
  end

  assign uo_out = res_q;
  assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Scoreboard bench for tt_um_serial_sub: stimulus queues expectations,
// a monitor pops them on every rising done and on directed checks.
module tb_tt_um_serial_sub;
  import serial_sub_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  logic [8:0]  exp_q[$];
  string       nm_q[$];
  logic [15:0] act_q[$];
  logic [15:0] req_q[$];

  always #5 clk = ~clk;

  tt_um_serial_sub dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Monitor: all comparisons happen here.
  initial begin
    logic        dprev;
    logic [8:0]  e;
    logic [8:0]  got;
    string       nm;
    logic [15:0] a;
    logic [15:0] r;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      got = {uio_out[PIN_BORROW], uo_out};
      if (uio_out[PIN_DONE] && !dprev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result: unexpected done, got diff=%h borrow=%b",
                   got[7:0], got[8]);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL result: got diff=%h borrow=%b, expected diff=%h borrow=%b",
                     got[7:0], got[8], e[7:0], e[8]);
          end
        end
      end
      dprev = uio_out[PIN_DONE];
      while (nm_q.size() > 0) begin
        nm = nm_q.pop_front();
        a  = act_q.pop_front();
        r  = req_q.pop_front();
        checks++;
        if (a !== r) begin
          errors++;
          $display("FAIL %s: got %h, expected %h", nm, a, r);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string nm, input logic [15:0] a,
                      input logic [15:0] r);
    nm_q.push_back(nm);
    act_q.push_back(a);
    req_q.push_back(r);
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    ui_in  = a;
    uio_in = 8'h01;
    cyc();
    ui_in  = b;
    uio_in = 8'h02;
    cyc();
    uio_in = 8'h00;
  endtask

  // Start a run, count busy cycles, optionally stall or poke it.
  task automatic launch(input logic [7:0] ed, input logic eb,
                        input int gap, input bit intrude);
    int n;
    exp_q.push_back({eb, ed});
    uio_in = 8'h04;
    cyc();
    uio_in = 8'h00;
    n = 0;
    while (uio_out[PIN_BUSY] && n < 40) begin
      ena = !(n >= 3 && n < 3 + gap);
      if (intrude && n == 2) begin
        ui_in  = 8'h99;
        uio_in = 8'h05;
      end else begin
        uio_in = 8'h00;
      end
      cyc();
      n++;
    end
    ena    = 1'b1;
    uio_in = 8'h00;
    push("busy_len", 16'(n), 16'(8 + gap));
    push("done", {15'd0, uio_out[PIN_DONE]}, 16'd1);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rd;

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    cyc(2);
    push("rst_uo_out", {8'd0, uo_out}, 16'h0000);
    push("rst_uio_out", {8'd0, uio_out}, 16'h0000);
    push("uio_oe", {8'd0, uio_oe}, 16'h0038);
    rst_n = 1'b1;
    cyc();

    load(8'h5A, 8'h23); launch(8'h37, 1'b0, 0, 1'b0);
    load(8'h10, 8'h20); launch(8'hF0, 1'b1, 0, 1'b0);
    load(8'hFF, 8'h01); launch(8'hFE, 1'b0, 0, 1'b0);
    load(8'h00, 8'h00); launch(8'h00, 1'b0, 0, 1'b0);

    // Operands are consumed by a run; a bare restart gives 0 - 0.
    load(8'hC3, 8'h3C); launch(8'h87, 1'b0, 0, 1'b0);
    launch(8'h00, 1'b0, 0, 1'b0);

    // Load plus start: load wins, from DONE and from IDLE.
    ui_in  = 8'h33;
    uio_in = 8'h05;
    cyc();
    uio_in = 8'h00;
    push("ld_st_busy_done", {8'd0, uio_out}, 16'h0000);
    ui_in  = 8'h44;
    uio_in = 8'h05;
    cyc();
    uio_in = 8'h00;
    cyc(2);
    push("ld_st_busy_idle", {15'd0, uio_out[PIN_BUSY]}, 16'd0);
    ui_in  = 8'h11;
    uio_in = 8'h02;
    cyc();
    uio_in = 8'h00;
    launch(8'h33, 1'b0, 0, 1'b0);

    // Strobes during RUN are dropped.
    load(8'h80, 8'h01); launch(8'h7F, 1'b0, 0, 1'b1);
    cyc(3);
    push("no_rerun", {8'd0, uio_out}, 16'h0010);

    // Reset in the 4th RUN cycle aborts with no partial result.
    load(8'h5A, 8'h23);
    uio_in = 8'h04;
    cyc();
    uio_in = 8'h00;
    cyc(3);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    push("abort_uo_out", {8'd0, uo_out}, 16'h0000);
    push("abort_uio_out", {8'd0, uio_out}, 16'h0000);
    load(8'h5A, 8'h23); launch(8'h37, 1'b0, 0, 1'b0);

    // Three disabled cycles stretch the run.
    load(8'h9C, 8'hA7); launch(8'hF5, 1'b1, 3, 1'b0);

    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rd = ra - rb;
      load(ra, rb);
      launch(rd, ra < rb, 0, 1'b0);
    end

    cyc(3);
    push("queue_empty", 16'(exp_q.size()), 16'd0);
    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
